// File: rtl/carregador_programa_pkg.sv
// carregador_programa_pkg: shared widths and FSM state encoding for the program loader
package carregador_programa_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    typedef enum logic [2:0] {OCIOSO, TAMANHO, CARGA, VERIFICA, PRONTO, ERRO} estado_t;
endpackage

// File: rtl/carregador_programa_if.sv
// carregador_programa_if: valid/ready byte stream; master = host, slave = loader
//   in_valid/in_data driven by master, in_ready driven by slave
interface carregador_programa_if #(parameter int DATA_W = carregador_programa_pkg::DATA_W);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    modport master (output in_valid, in_data, input in_ready);
    modport slave  (input in_valid, in_data, output in_ready);
endinterface

// File: rtl/carregador_programa_acumulador_xor.sv
// acumulador_xor: running XOR of accepted bytes
//   CLK, RESET_N (async active-low), clear, enable, din -> dout
module acumulador_xor #(parameter int W = 8) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    always_ff @(posedge CLK or negedge RESET_N)
        if (!RESET_N)    dout <= '0;
        else if (clear)  dout <= '0;
        else if (enable) dout <= dout ^ din;
endmodule

// File: rtl/carregador_programa.sv
// carregador_programa: streams a length-prefixed program into instruction memory, holding the CPU meanwhile
//   CLK, RESET_N (async active-low), start pulse, s (stream slave),
//   mem_we/mem_addr/mem_data write port, cpu_hold, done, erro
//   CARREGADOR_CHECKSUM_EN: expect a trailing XOR checksum byte, mismatch -> ERRO
module carregador_programa
    import carregador_programa_pkg::*;
#(
    parameter int ADDR_W = carregador_programa_pkg::ADDR_W,
    parameter int DATA_W = carregador_programa_pkg::DATA_W
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              start,
    carregador_programa_if.slave s,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              erro
);
    estado_t estado, prox;
    // one extra bit so a length byte of 0 means a full 2^ADDR_W words without wrapping
    logic [DATA_W:0] n;
    logic [ADDR_W:0] count;
    logic xfer;
    assign xfer = s.in_valid && s.in_ready;
`ifdef CARREGADOR_CHECKSUM_EN
    localparam estado_t FIM_CARGA = VERIFICA;
    logic [DATA_W-1:0] soma;
    acumulador_xor #(.W(DATA_W)) u_xor (
        .CLK(CLK), .RESET_N(RESET_N),
        .clear(estado == TAMANHO && xfer),
        .enable(estado == CARGA && xfer),
        .din(s.in_data), .dout(soma)
    );
    assign erro = estado == ERRO;
`else
    localparam estado_t FIM_CARGA = PRONTO;
    assign erro = 1'b0;
`endif
    assign s.in_ready = estado inside {TAMANHO, CARGA, VERIFICA};
    // hold is a function of state, so it falls on the same edge that registers the last write
    assign cpu_hold = estado != PRONTO;
    assign done = estado == PRONTO;
    always_ff @(posedge CLK or negedge RESET_N)
        if (!RESET_N) estado <= OCIOSO;
        else          estado <= prox;
    always_comb begin
        prox = estado;
        case (estado)
            OCIOSO, PRONTO, ERRO: prox = start ? TAMANHO : estado;
            TAMANHO: prox = xfer ? CARGA : estado;
            CARGA: prox = (xfer && count + 1'b1 == n) ? FIM_CARGA : estado;
`ifdef CARREGADOR_CHECKSUM_EN
            VERIFICA: prox = xfer ? ((s.in_data == soma) ? PRONTO : ERRO) : estado;
`endif
            default: prox = OCIOSO;
        endcase
    end
    always_ff @(posedge CLK or negedge RESET_N)
        if (!RESET_N) begin
            n <= '0;
            count <= '0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else begin
            mem_we <= estado == CARGA && xfer;
            if (estado == TAMANHO && xfer) begin
                n <= {s.in_data == '0, s.in_data};
                count <= '0;
            end
            if (estado == CARGA && xfer) begin
                mem_addr <= count[ADDR_W-1:0];
                mem_data <= s.in_data;
                count <= count + 1'b1;
            end
        end
endmodule

// File: tb/tb_carregador_programa.sv
// tb_carregador_programa: directed sessions with random payloads checked against a queue-based model
module tb_carregador_programa;
    logic CLK = 0, RESET_N = 0, start = 0;
    logic mem_we, cpu_hold, done, erro;
    logic [7:0] mem_addr, mem_data;
    int errors = 0, checks = 0;
    logic [16:0] got[$];
`ifdef CARREGADOR_CHECKSUM_EN
    localparam bit CK = 1;
`else
    localparam bit CK = 0;
`endif
    carregador_programa_if bus();
    carregador_programa dut (
        .CLK(CLK), .RESET_N(RESET_N), .start(start), .s(bus),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .cpu_hold(cpu_hold), .done(done), .erro(erro)
    );
    always #5 CLK = ~CLK;
    always @(negedge CLK) if (mem_we) got.push_back({cpu_hold, mem_addr, mem_data});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1;
        @(negedge CLK);
        start = 0;
    endtask

    task automatic send(input logic [7:0] b);
        int k = 0;
        bus.in_valid = 1;
        bus.in_data = b;
        while (!bus.in_ready && k < 50) begin
            @(negedge CLK);
            k++;
        end
        chk("accept", bus.in_ready, 1);
        @(negedge CLK);
        bus.in_valid = 0;
    endtask

    task automatic session(input logic [7:0] d[$], input int gap, input bit bad, input bit mid_start);
        logic [7:0] ck = 0;
        logic ok;
        got.delete();
        pulse_start();
        send(8'(d.size()));
        foreach (d[i]) begin
            send(d[i]);
            ck ^= d[i];
            if (i + 1 < d.size() || CK)
                repeat ($urandom_range(gap, 0)) begin
                    chk("ready_gap", bus.in_ready, 1);
                    @(negedge CLK);
                end
            if (mid_start && i == 1) pulse_start();
        end
`ifdef CARREGADOR_CHECKSUM_EN
        send(bad ? ~ck : ck);
`endif
        @(negedge CLK);
        ok = !(CK && bad);
        chk("done", done, ok);
        chk("erro", erro, !ok);
        chk("cpu_hold_end", cpu_hold, !ok);
        chk("ready_end", bus.in_ready, 0);
        chk("n_writes", got.size(), d.size());
        foreach (got[i])
            if (i < d.size()) chk("write", got[i], {1'(CK || i + 1 < d.size()), 8'(i), d[i]});
    endtask

    initial begin
        logic [7:0] q[$];
        bus.in_valid = 0;
        bus.in_data = 0;
        #12;
        chk("rst_ready", bus.in_ready, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_data", mem_data, 0);
        chk("rst_hold", cpu_hold, 1);
        chk("rst_done", done, 0);
        chk("rst_erro", erro, 0);
        @(negedge CLK);
        RESET_N = 1;
        @(negedge CLK);
        chk("idle_ready", bus.in_ready, 0);
        q = '{8'hA1, 8'hB2, 8'hC3};
        session(q, 0, 0, 0);
        session(q, 2, 0, 0);
        q.delete();
        repeat (1 + $urandom_range(20)) q.push_back(8'($urandom));
        session(q, 1, 0, 1);
        pulse_start();
        chk("restart_hold", cpu_hold, 1);
        chk("restart_ready", bus.in_ready, 1);
        chk("restart_done", done, 0);
        send(8'd5);
        repeat (3) send(8'($urandom));
        #2 RESET_N = 0;
        #1;
        chk("arst_ready", bus.in_ready, 0);
        chk("arst_we", mem_we, 0);
        chk("arst_addr", mem_addr, 0);
        chk("arst_data", mem_data, 0);
        chk("arst_hold", cpu_hold, 1);
        chk("arst_done", done, 0);
        @(negedge CLK);
        RESET_N = 1;
        @(negedge CLK);
        q = '{8'h11, 8'h22};
        session(q, 0, 0, 0);
        q.delete();
        for (int i = 0; i < 256; i++) q.push_back(8'(i));
        session(q, 1, 0, 0);
`ifdef CARREGADOR_CHECKSUM_EN
        q = '{8'h11, 8'h22};
        session(q, 0, 0, 0);
        session(q, 0, 1, 0);
        q.delete();
        repeat (1 + $urandom_range(10)) q.push_back(8'($urandom));
        session(q, 2, 1, 0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
